// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT host port and its row buffer.
package fft_pkg;

   localparam int NBANKS = 8;
   localparam int ROWW   = 3;
   localparam int COLW   = 3;
   localparam int DW     = 32;
   localparam int BUSW   = NBANKS * DW;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_START,
      ST_WAIT,
      ST_RD_ADDR,
      ST_RD_CAP,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/fft_host_port_if.sv
// Stream, FFT-core handshake and 8-bank memory signals of the host port.
interface fft_host_port_if;
   import fft_pkg::*;

   logic [DW-1:0]   s_data;
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   m_data;
   logic            m_valid;
   logic            m_ready;
   logic            m_last;
   logic            en_fft;
   logic            done_fft;
   logic            mem_sel;
   logic            memwrite_en;
   logic [ROWW-1:0] mem_wr_addr;
   logic [ROWW-1:0] mem_rd_addr;
   logic [BUSW-1:0] wr_data;
   logic [BUSW-1:0] rd_data;
   logic            busy;
   logic            err_timeout;

   modport master (
      input  s_data, s_valid, m_ready, done_fft, rd_data,
      output s_ready, m_data, m_valid, m_last, en_fft, mem_sel,
             memwrite_en, mem_wr_addr, mem_rd_addr, wr_data, busy, err_timeout
   );

   modport slave (
      output s_data, s_valid, m_ready, done_fft, rd_data,
      input  s_ready, m_data, m_valid, m_last, en_fft, mem_sel,
             memwrite_en, mem_wr_addr, mem_rd_addr, wr_data, busy, err_timeout
   );

endinterface

// File: rtl/fft_row_buffer.sv
// Eight-word row register: one word per bank, filled word-by-word or as a whole row.
module fft_row_buffer
   import fft_pkg::*;
(
   input  logic            clk,
   input  logic            word_we,
   input  logic [COLW-1:0] col,
   input  logic [DW-1:0]   word_in,
   input  logic            row_we,
   input  logic [BUSW-1:0] row_in,
   output logic [DW-1:0]   word_out,
   output logic [BUSW-1:0] row_out
);

   logic [DW-1:0] words [NBANKS];

   // Datapath only; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (row_we) begin
         for (int k = 0; k < NBANKS; k++) begin
            words[k] <= row_in[k*DW +: DW];
         end
      end else if (word_we) begin
         words[col] <= word_in;
      end
   end

   assign word_out = words[col];

   always_comb begin
      row_out = '0;
      for (int k = 0; k < NBANKS; k++) begin
         row_out[k*DW +: DW] = words[k];
      end
   end

endmodule

// File: rtl/fft_host_port.sv
// Host side of the 64-point FFT core: packs input rows into the banks, starts the
// core, waits for completion (with timeout) and streams the results back out.
module fft_host_port
   import fft_pkg::*;
#(
   parameter int NPTS    = 64,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   fft_host_port_if.master bus
);

   localparam int              CNTW     = $clog2(TIMEOUT + 1);
   localparam logic [ROWW-1:0] LAST_ROW = ROWW'(NPTS / NBANKS - 1);
   localparam logic [COLW-1:0] LAST_COL = COLW'(NBANKS - 1);
   localparam logic [CNTW-1:0] EXPIRE   = CNTW'(TIMEOUT - 1);

   state_t          state;
   logic [ROWW-1:0] row;
   logic [COLW-1:0] col;
   logic [CNTW-1:0] cnt;
   logic            load_rdy;
   logic            out_vld;
   logic            start_pls;
   logic            own_mem;
   logic            wr_stb;
   logic            err_flag;

   logic            take;
   logic            give;
   logic [DW-1:0]   word_out;
   logic [BUSW-1:0] row_out;

   assign take = bus.s_valid & load_rdy;
   assign give = out_vld & bus.m_ready;

   fft_row_buffer u_row_buffer (
      .clk      (clk),
      .word_we  (take),
      .col      (col),
      .word_in  (bus.s_data),
      .row_we   (state == ST_RD_CAP),
      .row_in   (bus.rd_data),
      .word_out (word_out),
      .row_out  (row_out)
   );

   // cnt holds the number of cycles since the en_fft cycle while the core owns memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         row       <= '0;
         col       <= '0;
         cnt       <= '0;
         load_rdy  <= 1'b1;
         out_vld   <= 1'b0;
         start_pls <= 1'b0;
         own_mem   <= 1'b1;
         wr_stb    <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         start_pls <= 1'b0;
         wr_stb    <= 1'b0;
         case (state)
            ST_IDLE, ST_LOAD: begin
               if (take) begin
                  err_flag <= 1'b0;
                  col      <= col + 1'b1;
                  state    <= ST_LOAD;
                  if (col == LAST_COL) begin
                     state    <= ST_WRITE;
                     load_rdy <= 1'b0;
                     wr_stb   <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               row <= row + 1'b1;
               if (row == LAST_ROW) begin
                  state     <= ST_START;
                  start_pls <= 1'b1;
                  own_mem   <= 1'b0;
                  cnt       <= '0;
               end else begin
                  state    <= ST_LOAD;
                  load_rdy <= 1'b1;
               end
            end
            ST_START: begin
               cnt   <= cnt + 1'b1;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt <= cnt + 1'b1;
               // A completion in the expiry cycle still counts as success.
               if (bus.done_fft) begin
                  state   <= ST_RD_ADDR;
                  own_mem <= 1'b1;
                  row     <= '0;
               end else if (cnt == EXPIRE) begin
                  state    <= ST_IDLE;
                  own_mem  <= 1'b1;
                  err_flag <= 1'b1;
                  load_rdy <= 1'b1;
               end
            end
            ST_RD_ADDR: begin
               state <= ST_RD_CAP;
            end
            ST_RD_CAP: begin
               col     <= '0;
               out_vld <= 1'b1;
               state   <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (give) begin
                  col <= col + 1'b1;
                  if (col == LAST_COL) begin
                     out_vld <= 1'b0;
                     if (row == LAST_ROW) begin
                        state    <= ST_IDLE;
                        row      <= '0;
                        load_rdy <= 1'b1;
                     end else begin
                        row   <= row + 1'b1;
                        state <= ST_RD_ADDR;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.s_ready     = load_rdy;
   assign bus.m_valid     = out_vld;
   assign bus.m_data      = word_out;
   assign bus.m_last      = out_vld & (row == LAST_ROW) & (col == LAST_COL);
   assign bus.en_fft      = start_pls;
   assign bus.mem_sel     = own_mem;
   assign bus.memwrite_en = wr_stb;
   assign bus.mem_wr_addr = row;
   assign bus.mem_rd_addr = row;
   assign bus.wr_data     = row_out;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.err_timeout = err_flag;

endmodule

// File: tb/tb_fft_host_port.sv
// Frame-level bench for fft_host_port with a bank memory and FFT core model.
module tb_fft_host_port;
   import fft_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fft_host_port_if bus ();

   fft_host_port #(.NPTS(64), .TIMEOUT(255)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int core_delay;
      int ready_mode;
      bit give_done;
      bit rand_data;
      int exp_words;
      bit exp_err;
      int exp_sel_low;
   } vec_t;

   vec_t vecs [7];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   logic [31:0] bank [8][8];
   logic        core_wr;
   int          core_delay;
   int          ready_mode;
   logic        mon_clr;

   logic [31:0] out_q [$];
   bit          last_q [$];
   int          wr_addr_q [$];
   int          en_cnt, en_cyc, last_wr_cyc, sel_low, own_err, stall_err, err_cyc;
   bit          prev_stall;
   logic [31:0] prev_data;
   logic        prev_err;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] read_row(input logic [2:0] a);
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = bank[k][a];
      return r;
   endfunction

   // Banks: written by the host port when it owns memory, or transformed by the core.
   always @(posedge clk) begin
      if (core_wr) begin
         for (int k = 0; k < 8; k++)
            for (int r = 0; r < 8; r++)
               bank[k][r] <= bank[k][r] + 32'h1000;
      end else if (bus.mem_sel && bus.memwrite_en) begin
         for (int k = 0; k < 8; k++)
            bank[k][bus.mem_wr_addr] <= bus.wr_data[32*k +: 32];
      end
      bus.rd_data <= read_row(bus.mem_rd_addr);
   end

   // FFT core: result = input + 0x1000, done pulse core_delay cycles after en_fft.
   initial begin
      bus.done_fft = 1'b0;
      core_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.en_fft && core_delay > 0) begin
            repeat (core_delay) begin
               @(posedge clk);
               #1;
            end
            bus.done_fft = 1'b1;
            core_wr = 1'b1;
            @(posedge clk);
            #1;
            bus.done_fft = 1'b0;
            core_wr = 1'b0;
         end
      end
   end

   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (mon_clr) begin
         out_q.delete();
         last_q.delete();
         wr_addr_q.delete();
         en_cnt <= 0; en_cyc <= 0; last_wr_cyc <= 0; sel_low <= 0;
         own_err <= 0; stall_err <= 0; err_cyc <= 0;
         prev_stall <= 1'b0;
         prev_err <= bus.err_timeout;
      end else if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (bus.memwrite_en) begin
            if (!bus.mem_sel) own_err <= own_err + 1;
            wr_addr_q.push_back(int'(bus.mem_wr_addr));
            last_wr_cyc <= cyc;
         end
         if (bus.en_fft) begin
            en_cnt <= en_cnt + 1;
            en_cyc <= cyc;
         end
         if (!bus.mem_sel) sel_low <= sel_low + 1;
         if (bus.err_timeout && !prev_err) err_cyc <= cyc;
         prev_err <= bus.err_timeout;
         if (bus.m_valid && bus.m_ready) begin
            out_q.push_back(bus.m_data);
            last_q.push_back(bus.m_last);
         end
         if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data))
            stall_err <= stall_err + 1;
         prev_stall <= bus.m_valid && !bus.m_ready;
         prev_data  <= bus.m_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, output int ok);
      int   w;
      logic rdy;
      ok = 0;
      w = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      while (w < 40) begin
         rdy = bus.s_ready;
         @(posedge clk);
         #1;
         w++;
         if (rdy) begin
            ok = 1;
            break;
         end
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      logic [31:0] in_v [64];
      logic [31:0] exp_q [$];
      int ok, accepted, bad, w, lastcnt, lastidx;
      core_delay = v.give_done ? v.core_delay : 0;
      ready_mode = v.ready_mode;
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
      @(posedge clk);
      #1;
      for (int n = 0; n < 64; n++) in_v[n] = v.rand_data ? $urandom : 32'(n);
      accepted = 0;
      for (int n = 0; n < 64; n++) begin
         send(in_v[n], ok);
         accepted += ok;
         if (n == 0) check($sformatf("v%0d_err_clear", idx), 32'(bus.err_timeout), 0);
      end
      check($sformatf("v%0d_load_accept", idx), accepted, 64);
      @(posedge clk);
      #1;
      bad = 0;
      for (int n = 0; n < 64; n++) if (bank[n % 8][n / 8] !== in_v[n]) bad++;
      check($sformatf("v%0d_bank_map", idx), bad, 0);
      w = 0;
      while (bus.busy && w < 3000) begin
         @(posedge clk);
         #1;
         w++;
      end
      check($sformatf("v%0d_frame_end_busy", idx), 32'(bus.busy), 0);
      @(negedge clk);
      #1;
      if (v.exp_words > 0) for (int n = 0; n < 64; n++) exp_q.push_back(in_v[n] + 32'h1000);
      check($sformatf("v%0d_words", idx), out_q.size(), v.exp_words);
      bad = 0;
      for (int n = 0; n < out_q.size() && n < exp_q.size(); n++) if (out_q[n] !== exp_q[n]) bad++;
      check($sformatf("v%0d_data", idx), bad, 0);
      lastcnt = 0;
      lastidx = -1;
      foreach (last_q[i]) if (last_q[i]) begin lastcnt++; lastidx = i; end
      check($sformatf("v%0d_last_cnt", idx), lastcnt, (v.exp_words > 0) ? 1 : 0);
      if (v.exp_words > 0) check($sformatf("v%0d_last_pos", idx), lastidx, 63);
      check($sformatf("v%0d_err_timeout", idx), 32'(bus.err_timeout), 32'(v.exp_err));
      if (v.exp_err) check($sformatf("v%0d_err_cycle", idx), err_cyc - en_cyc, 255);
      check($sformatf("v%0d_wr_count", idx), wr_addr_q.size(), 8);
      bad = 0;
      foreach (wr_addr_q[i]) if (wr_addr_q[i] != i) bad++;
      check($sformatf("v%0d_wr_addr_order", idx), bad, 0);
      check($sformatf("v%0d_en_count", idx), en_cnt, 1);
      check($sformatf("v%0d_en_after_write", idx), en_cyc - last_wr_cyc, 1);
      check($sformatf("v%0d_sel_low_cycles", idx), sel_low, v.exp_sel_low);
      check($sformatf("v%0d_write_while_core", idx), own_err, 0);
      check($sformatf("v%0d_stall_hold", idx), stall_err, 0);
   endtask

   initial begin
      int ok;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      ready_mode  = 0;
      core_delay  = 0;
      mon_clr     = 1'b0;
      rst_n       = 1'b0;

      //          delay mode done rand words err sel_low
      vecs[0] = '{196, 0, 1'b1, 1'b0, 64, 1'b0, 197};
      vecs[1] = '{196, 1, 1'b1, 1'b1, 64, 1'b0, 197};
      vecs[2] = '{20,  2, 1'b1, 1'b1, 64, 1'b0, 21};
      vecs[3] = '{0,   0, 1'b0, 1'b1, 0,  1'b1, 255};
      vecs[4] = '{3,   2, 1'b1, 1'b1, 64, 1'b0, 4};
      vecs[5] = '{254, 1, 1'b1, 1'b1, 64, 1'b0, 255};
      vecs[6] = '{255, 0, 1'b1, 1'b1, 0,  1'b1, 255};

      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 32'(bus.s_ready), 1);
      check("rst_mem_sel", 32'(bus.mem_sel), 1);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_m_valid", 32'(bus.m_valid), 0);
      check("rst_en_fft", 32'(bus.en_fft), 0);
      check("rst_memwrite", 32'(bus.memwrite_en), 0);
      check("rst_err", 32'(bus.err_timeout), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) send(32'(i), ok);
      check("midload_busy", 32'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      check("midload_m_valid", 32'(bus.m_valid), 0);
      check("midload_en_fft", 32'(bus.en_fft), 0);
      check("midload_memwrite", 32'(bus.memwrite_en), 0);
      check("midload_mem_sel", 32'(bus.mem_sel), 1);
      check("midload_busy_rst", 32'(bus.busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) send(32'(i), ok);
      check("midwrite_memwrite_on", 32'(bus.memwrite_en), 1);
      rst_n = 1'b0;
      #1;
      check("midwrite_memwrite_off", 32'(bus.memwrite_en), 0);
      check("midwrite_s_ready", 32'(bus.s_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
